// File: rtl/lcd1602_pkg.sv
// Shared types and constants for the HD44780-compatible LCD responder.
// AC stepping rules live here so the top and any future mirror logic agree.
package lcd1602_pkg;

    localparam logic [7:0] SPACE       = 8'h20;
    localparam logic [6:0] AC_L0_END   = 7'h27;
    localparam logic [6:0] AC_L1_START = 7'h40;
    localparam logic [6:0] AC_L1_END   = 7'h67;
    localparam logic [5:0] DDRAM_HOLE  = 6'h28;

    localparam logic [7:0] OP_DDRAM = 8'h80;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_CLEAR = 8'h01;

    typedef enum logic [1:0] {ST_IDLE, ST_EN_HIGH, ST_EXEC} state_e;
    typedef enum logic {TGT_DDRAM, TGT_CGRAM} target_e;

    typedef struct packed {
        logic       en;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } bus_t;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } cmd_t;

    // EN resets high so a pulse already in flight at reset release is not seen as a rise
    localparam bus_t BUS_IDLE = '{en: 1'b1, rs: 1'b0, rw: 1'b0, data: 8'h00};

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == AC_L0_END)      return AC_L1_START;
            else if (ac == AC_L1_END) return 7'h00;
            else                      return ac + 7'd1;
        end else begin
            if (ac == 7'h00)            return AC_L1_END;
            else if (ac == AC_L1_START) return AC_L0_END;
            else                        return ac - 7'd1;
        end
    endfunction

    function automatic logic ac_visible(input logic [6:0] ac);
        return ac[5:4] == 2'b00;
    endfunction

    function automatic logic [4:0] ac_index(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

endpackage

// File: rtl/lcd_busy_timer.sv
// Down-counter producing the HD44780 busy flag; a load overrides the count.
module lcd_busy_timer #(
    parameter int              CNT_W     = 17,
    parameter logic [CNT_W-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= RESET_VAL;
        else        cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/lcd1602_responder.sv
// Panel-side HD44780/1602 model: synchronizes the bus, executes on EN fall,
// keeps a 2x16 DDRAM image and answers status/data reads.
module lcd1602_responder
    import lcd1602_pkg::*;
#(
    parameter int BUSY_SHORT_CYC = 2000,
    parameter int BUSY_LONG_CYC  = 76500,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA_IN,
    output logic [7:0] LCD_DATA_OUT,
    output logic       LCD_DATA_OE,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic       disp_on,
    output logic [6:0] cursor_addr,
    output logic       cmd_dropped
);
    localparam int CNT_W = $clog2(BUSY_LONG_CYC + 1);

    bus_t [SYNC_STAGES-1:0] sync_q, sync_d;
    bus_t             bus_in, bus_s;
    state_e           state_q, state_d;
    target_e          tgt_q, tgt_d;
    cmd_t             cmd_q, cmd_d;
    logic             en_prev_q, en_prev_d;
    logic [6:0]       ac_q, ac_d;
    logic             id_q, id_d;
    logic [2:0]       dcb_q, dcb_d;
    logic [31:0][7:0] ddram_q, ddram_d;
    logic             clearing_q, clearing_d;
    logic [4:0]       clr_idx_q, clr_idx_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             oe_q, oe_d;
    logic [7:0]       rd_char_q, rd_char_d;
    logic             dropped_q, dropped_d;
    logic             ld, busy_w, en_rise;
    logic [CNT_W-1:0] ld_val;
    logic [7:0]       rd_val, status;

    lcd_busy_timer #(.CNT_W(CNT_W), .RESET_VAL(CNT_W'(BUSY_LONG_CYC))) u_busy (
        .clk(iclk), .rst_n(irst), .load(ld), .load_val(ld_val), .busy(busy_w)
    );

    always_comb begin
        bus_in = '{en: LCD_EN, rs: LCD_RS, rw: LCD_RW, data: LCD_DATA_IN};
        sync_d = sync_q;
        sync_d[0] = bus_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        bus_s = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cmd_d      = cmd_q;
        ac_d       = ac_q;
        id_d       = id_q;
        dcb_d      = dcb_q;
        ddram_d    = ddram_q;
        clearing_d = clearing_q;
        clr_idx_d  = clr_idx_q;
        data_out_d = data_out_q;
        oe_d       = oe_q;
        dropped_d  = 1'b0;
        ld         = 1'b0;
        ld_val     = CNT_W'(BUSY_SHORT_CYC);
        en_prev_d  = bus_s.en;
        en_rise    = bus_s.en & ~en_prev_q;
        rd_val     = ac_visible(ac_q) ? ddram_q[ac_index(ac_q)] : SPACE;
        status     = {busy_w, ac_q};
        rd_char_d  = ddram_q[rd_addr];

        // Clear sweeps one byte per cycle, well inside its long busy window
        if (clearing_q) begin
            ddram_d[clr_idx_q] = SPACE;
            clr_idx_d = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) clearing_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_rise) begin
                    state_d = ST_EN_HIGH;
                    cmd_d   = '{rs: bus_s.rs, rw: bus_s.rw, data: bus_s.data};
                    oe_d    = bus_s.rw;
                    if (bus_s.rw) data_out_d = bus_s.rs ? rd_val : status;
                end
            end
            ST_EN_HIGH: begin
                if (bus_s.en) begin
                    cmd_d = '{rs: bus_s.rs, rw: bus_s.rw, data: bus_s.data};
                    oe_d  = bus_s.rw;
                    if (bus_s.rw) data_out_d = bus_s.rs ? rd_val : status;
                end else begin
                    state_d = ST_EXEC;
                    oe_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (cmd_q.rw) begin
                    if (cmd_q.rs) ac_d = ac_step(ac_q, id_q);
                end else if (busy_w) begin
                    dropped_d = 1'b1;
                end else if (cmd_q.rs) begin
                    ld = 1'b1;
                    if (tgt_q == TGT_DDRAM && ac_visible(ac_q))
                        ddram_d[ac_index(ac_q)] = cmd_q.data;
                    ac_d = ac_step(ac_q, id_q);
                end else begin
                    ld = 1'b1;
                    if (|(cmd_q.data & OP_DDRAM)) begin
                        tgt_d = TGT_DDRAM;
                        ac_d  = (cmd_q.data[5:0] >= DDRAM_HOLE) ? 7'h00 : cmd_q.data[6:0];
                    end else if (|(cmd_q.data & OP_CGRAM)) begin
                        tgt_d = TGT_CGRAM;
                    end else if (|(cmd_q.data & OP_FUNC)) begin
                        tgt_d = tgt_q;
                    end else if (|(cmd_q.data & OP_SHIFT)) begin
                        if (!cmd_q.data[3]) ac_d = ac_step(ac_q, cmd_q.data[2]);
                    end else if (|(cmd_q.data & OP_DISP)) begin
                        dcb_d = cmd_q.data[2:0];
                    end else if (|(cmd_q.data & OP_ENTRY)) begin
                        id_d = cmd_q.data[1];
                    end else if (|(cmd_q.data & OP_HOME)) begin
                        ac_d   = 7'h00;
                        ld_val = CNT_W'(BUSY_LONG_CYC);
                    end else if (|(cmd_q.data & OP_CLEAR)) begin
                        ac_d       = 7'h00;
                        id_d       = 1'b1;
                        clearing_d = 1'b1;
                        clr_idx_d  = 5'd0;
                        ld_val     = CNT_W'(BUSY_LONG_CYC);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BUS_IDLE;
            state_q    <= ST_IDLE;
            tgt_q      <= TGT_DDRAM;
            cmd_q      <= '0;
            en_prev_q  <= 1'b1;
            ac_q       <= 7'h00;
            id_q       <= 1'b1;
            dcb_q      <= 3'b000;
            ddram_q    <= {32{SPACE}};
            clearing_q <= 1'b0;
            clr_idx_q  <= 5'd0;
            data_out_q <= 8'h00;
            oe_q       <= 1'b0;
            rd_char_q  <= SPACE;
            dropped_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            cmd_q      <= cmd_d;
            en_prev_q  <= en_prev_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            dcb_q      <= dcb_d;
            ddram_q    <= ddram_d;
            clearing_q <= clearing_d;
            clr_idx_q  <= clr_idx_d;
            data_out_q <= data_out_d;
            oe_q       <= oe_d;
            rd_char_q  <= rd_char_d;
            dropped_q  <= dropped_d;
        end
    end

    assign LCD_DATA_OUT = data_out_q;
    assign LCD_DATA_OE  = oe_q;
    assign rd_char      = rd_char_q;
    assign busy         = busy_w;
    assign disp_on      = dcb_q[2];
    assign cursor_addr  = ac_q;
    assign cmd_dropped  = dropped_q;

endmodule
